// File: rtl/axi3_pkg.sv
// Shared types for the AXI3 register file: response codes, burst encodings,
// FSM state enums and the byte-strobe merge helper.
package axi3_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  function automatic logic burst_ok(input burst_e burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi3_burst_idx.sv
// Next register index for a burst beat: INCR steps modulo the register count
// (natural wrap of the index width), FIXED and anything else hold.
module axi3_burst_idx
  import axi3_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] cur_idx,
  input  burst_e           burst,
  output logic [IDX_W-1:0] nxt_idx
);

  // Select the follow-on index from the burst type
  always_comb begin
    nxt_idx = cur_idx;
    case (burst)
      BURST_INCR:  nxt_idx = cur_idx + IDX_W'(1);
      BURST_FIXED: nxt_idx = cur_idx;
      default:     nxt_idx = cur_idx;
    endcase
  end

endmodule

// File: rtl/axi3_regfile.sv
// AXI3 slave register file for the PS7 GP port: N_REG x 32-bit registers,
// independent read/write FSMs. Optional macro AXI_REGFILE_CYCLE_CNTR_EN.
module axi3_regfile
  import axi3_pkg::*;
#(
  parameter int ID_W    = 12,
  parameter int N_REG   = 8,
  parameter int LED_REG = 0,
  parameter int LED_W   = 8
) (
  input  logic             i_clk0,
  input  logic             i_rst,
  input  logic [ID_W-1:0]  i_AXI_AWID,
  input  logic [31:0]      i_AXI_AWADDR,
  input  logic [3:0]       i_AXI_AWLEN,
  input  logic [1:0]       i_AXI_AWBURST,
  input  logic             i_AXI_AWVALID,
  output logic             o_AXI_AWREADY,
  input  logic [31:0]      i_AXI_WDATA,
  input  logic [3:0]       i_AXI_WSTRB,
  input  logic             i_AXI_WLAST,
  input  logic             i_AXI_WVALID,
  output logic             o_AXI_WREADY,
  output logic [ID_W-1:0]  o_AXI_BID,
  output logic [1:0]       o_AXI_BRESP,
  output logic             o_AXI_BVALID,
  input  logic             i_AXI_BREADY,
  input  logic [ID_W-1:0]  i_AXI_ARID,
  input  logic [31:0]      i_AXI_ARADDR,
  input  logic [3:0]       i_AXI_ARLEN,
  input  logic [1:0]       i_AXI_ARBURST,
  input  logic             i_AXI_ARVALID,
  output logic             o_AXI_ARREADY,
  output logic [ID_W-1:0]  o_AXI_RID,
  output logic [31:0]      o_AXI_RDATA,
  output logic [1:0]       o_AXI_RRESP,
  output logic             o_AXI_RLAST,
  output logic             o_AXI_RVALID,
  input  logic             i_AXI_RREADY,
  output logic [LED_W-1:0] o_led
);

  localparam int IDX_W = $clog2(N_REG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);
  localparam logic [IDX_W-1:0] LED_IDX  = IDX_W'(LED_REG);

  logic [31:0] regs_r [N_REG];

  wr_state_e        w_state_r;
  logic             awready_r, wready_r, bvalid_r, werr_r;
  logic [ID_W-1:0]  bid_r;
  logic [1:0]       bresp_r;
  logic [IDX_W-1:0] widx_r, widx_nxt_s;
  burst_e           wburst_r;
  logic [3:0]       wlen_r, wcnt_r;
  logic             w_beat_s, w_en_s, w_beat_err_s;

  rd_state_e        r_state_r;
  logic             arready_r, rvalid_r, rlast_r;
  logic [ID_W-1:0]  rid_r;
  logic [31:0]      rdata_r;
  logic [1:0]       rresp_r;
  logic [IDX_W-1:0] ridx_r, ridx_nxt_s, ar_idx_s;
  burst_e           rburst_r, ar_burst_s, aw_burst_s;
  logic [3:0]       rlen_r, rcnt_r;

  logic [31:0]      led_wr_s, led_word_s;
  logic [LED_W-1:0] led_r;
  logic             unused_s;

  assign ar_idx_s   = i_AXI_ARADDR[2 +: IDX_W];
  assign ar_burst_s = burst_e'(i_AXI_ARBURST);
  assign aw_burst_s = burst_e'(i_AXI_AWBURST);
  assign unused_s   = ^{i_AXI_AWADDR, i_AXI_ARADDR, led_word_s};

  axi3_burst_idx #(.IDX_W(IDX_W)) u_widx (
    .cur_idx (widx_r),
    .burst   (wburst_r),
    .nxt_idx (widx_nxt_s)
  );

  axi3_burst_idx #(.IDX_W(IDX_W)) u_ridx (
    .cur_idx (ridx_r),
    .burst   (rburst_r),
    .nxt_idx (ridx_nxt_s)
  );

  // Qualify the current W beat: whether it commits and whether it flags SLVERR
  always_comb begin
    w_beat_s = (w_state_r == W_DATA) && wready_r && i_AXI_WVALID;
`ifdef AXI_REGFILE_CYCLE_CNTR_EN
    w_en_s       = w_beat_s && burst_ok(wburst_r) && (widx_r != LAST_IDX);
    w_beat_err_s = ((wcnt_r == wlen_r) ? !i_AXI_WLAST : i_AXI_WLAST) ||
                   (widx_r == LAST_IDX);
`else
    w_en_s       = w_beat_s && burst_ok(wburst_r);
    w_beat_err_s = (wcnt_r == wlen_r) ? !i_AXI_WLAST : i_AXI_WLAST;
`endif
  end

  // Write FSM: AW accept, W beats counted against AWLEN, then B response
  always_ff @(posedge i_clk0 or posedge i_rst) begin
    if (i_rst) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      bresp_r   <= AXI_RESP_OKAY;
      widx_r    <= '0;
      wburst_r  <= BURST_FIXED;
      wlen_r    <= 4'd0;
      wcnt_r    <= 4'd0;
      werr_r    <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (i_AXI_AWVALID) begin
            bid_r     <= i_AXI_AWID;
            widx_r    <= i_AXI_AWADDR[2 +: IDX_W];
            wburst_r  <= aw_burst_s;
            wlen_r    <= i_AXI_AWLEN;
            wcnt_r    <= 4'd0;
            werr_r    <= !burst_ok(aw_burst_s);
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat_s) begin
            widx_r <= widx_nxt_s;
            wcnt_r <= wcnt_r + 4'd1;
            if (wcnt_r == wlen_r) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= (werr_r || w_beat_err_s) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              werr_r <= werr_r || w_beat_err_s;
            end
          end
        end
        W_RESP: begin
          if (i_AXI_BREADY) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b1;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Register array with strobed writes; top slot optionally a cycle counter
  always_ff @(posedge i_clk0 or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_REG; i++) regs_r[i] <= 32'd0;
    end else begin
      for (int i = 0; i < N_REG; i++) begin
        if (w_en_s && (widx_r == IDX_W'(i))) begin
          regs_r[i] <= merge_strb(regs_r[i], i_AXI_WDATA, i_AXI_WSTRB);
        end
      end
`ifdef AXI_REGFILE_CYCLE_CNTR_EN
      regs_r[N_REG-1] <= regs_r[N_REG-1] + 32'd1;
`endif
    end
  end

  // LED follows the register's next value so it updates with the write itself
  assign led_wr_s = (w_en_s && (widx_r == LED_IDX)) ?
                    merge_strb(regs_r[LED_REG], i_AXI_WDATA, i_AXI_WSTRB) :
                    regs_r[LED_REG];
`ifdef AXI_REGFILE_CYCLE_CNTR_EN
  assign led_word_s = (LED_REG == N_REG - 1) ? (regs_r[LED_REG] + 32'd1) : led_wr_s;
`else
  assign led_word_s = led_wr_s;
`endif

  // Registered LED output
  always_ff @(posedge i_clk0 or posedge i_rst) begin
    if (i_rst) begin
      led_r <= '0;
    end else begin
      led_r <= led_word_s[LED_W-1:0];
    end
  end

  // Read FSM: AR accept, then one R beat per RREADY, RLAST on beat ARLEN
  always_ff @(posedge i_clk0 or posedge i_rst) begin
    if (i_rst) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      rdata_r   <= 32'd0;
      rresp_r   <= AXI_RESP_OKAY;
      ridx_r    <= '0;
      rburst_r  <= BURST_FIXED;
      rlen_r    <= 4'd0;
      rcnt_r    <= 4'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (i_AXI_ARVALID) begin
            rid_r     <= i_AXI_ARID;
            ridx_r    <= ar_idx_s;
            rburst_r  <= ar_burst_s;
            rlen_r    <= i_AXI_ARLEN;
            rcnt_r    <= 4'd0;
            rdata_r   <= burst_ok(ar_burst_s) ? regs_r[ar_idx_s] : 32'd0;
            rresp_r   <= burst_ok(ar_burst_s) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            rlast_r   <= (i_AXI_ARLEN == 4'd0);
            rvalid_r  <= 1'b1;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (i_AXI_RREADY) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              ridx_r  <= ridx_nxt_s;
              rcnt_r  <= rcnt_r + 4'd1;
              rdata_r <= burst_ok(rburst_r) ? regs_r[ridx_nxt_s] : 32'd0;
              rlast_r <= ((rcnt_r + 4'd1) == rlen_r);
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  assign o_AXI_AWREADY = awready_r;
  assign o_AXI_WREADY  = wready_r;
  assign o_AXI_BID     = bid_r;
  assign o_AXI_BRESP   = bresp_r;
  assign o_AXI_BVALID  = bvalid_r;
  assign o_AXI_ARREADY = arready_r;
  assign o_AXI_RID     = rid_r;
  assign o_AXI_RDATA   = rdata_r;
  assign o_AXI_RRESP   = rresp_r;
  assign o_AXI_RLAST   = rlast_r;
  assign o_AXI_RVALID  = rvalid_r;
  assign o_led         = led_r;

endmodule

// File: tb/tb_axi3_regfile.sv
// Scoreboard bench for axi3_regfile (default build, N_REG=8): directed bursts
// push expected B/R responses; a negedge monitor pops and compares them.
module tb_axi3_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [7:0]  led;

  always #5 clk = ~clk;

  axi3_regfile dut (
    .i_clk0(clk), .i_rst(rst),
    .i_AXI_AWID(awid), .i_AXI_AWADDR(awaddr), .i_AXI_AWLEN(awlen), .i_AXI_AWBURST(awburst),
    .i_AXI_AWVALID(awvalid), .o_AXI_AWREADY(awready),
    .i_AXI_WDATA(wdata), .i_AXI_WSTRB(wstrb), .i_AXI_WLAST(wlast), .i_AXI_WVALID(wvalid),
    .o_AXI_WREADY(wready),
    .o_AXI_BID(bid), .o_AXI_BRESP(bresp), .o_AXI_BVALID(bvalid), .i_AXI_BREADY(bready),
    .i_AXI_ARID(arid), .i_AXI_ARADDR(araddr), .i_AXI_ARLEN(arlen), .i_AXI_ARBURST(arburst),
    .i_AXI_ARVALID(arvalid), .o_AXI_ARREADY(arready),
    .o_AXI_RID(rid), .o_AXI_RDATA(rdata), .o_AXI_RRESP(rresp), .o_AXI_RLAST(rlast),
    .o_AXI_RVALID(rvalid), .i_AXI_RREADY(rready),
    .o_led(led)
  );

  typedef struct packed { logic [11:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [11:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] wd[16];
  logic [3:0]  ws[16];
  logic        wl[16];
  logic        rr_toggle = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic beat(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
    wd[i] = d; ws[i] = s; wl[i] = l;
  endtask

  task automatic push_r(input logic [11:0] id, input logic [31:0] d, input logic [1:0] rs, input logic l);
    rq.push_back('{id, d, rs, l});
  endtask

  // which: 0 AWREADY, 1 WREADY, 2 ARREADY; returns at posedge+1 after the handshake
  task automatic hs_wait(input int which, input string nm);
    int  t;
    logic rdy;
    t = 0;
    rdy = 1'b0;
    do begin
      @(negedge clk);
      t++;
      rdy = (which == 0) ? awready : ((which == 1) ? wready : arready);
    end while (!rdy && t < 64);
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: ready=0 expected 1", nm);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 200) begin
      @(posedge clk); t++;
    end
    #1;
    if (bq.size() != 0 || rq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: pending b=%0d r=%0d expected 0", bq.size(), rq.size());
      bq.delete(); rq.delete();
    end
  endtask

  task automatic do_write(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [1:0] exp_resp, input bit wait_b);
    bq.push_back('{id, exp_resp});
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    hs_wait(0, "aw");
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      hs_wait(1, "w");
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (wait_b) drain();
  endtask

  task automatic do_read(input logic [11:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    hs_wait(2, "ar");
    arvalid = 1'b0;
    drain();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_awready"}, awready, 1'b1);
    chk({tag, "_arready"}, arready, 1'b1);
    chk({tag, "_wready"},  wready,  1'b0);
    chk({tag, "_bvalid"},  bvalid,  1'b0);
    chk({tag, "_rvalid"},  rvalid,  1'b0);
    chk({tag, "_rlast"},   rlast,   1'b0);
    chk({tag, "_bid"},     bid,     12'h000);
    chk({tag, "_rid"},     rid,     12'h000);
    chk({tag, "_rdata"},   rdata,   32'h0);
    chk({tag, "_bresp"},   bresp,   2'b00);
    chk({tag, "_rresp"},   rresp,   2'b00);
    chk({tag, "_led"},     led,     8'h00);
  endtask

  // RREADY pattern source: held high, or 1,0,0 repeating during stall tests
  initial begin
    int ph;
    ph = 0;
    rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rr_toggle) begin
        rready = (ph == 0);
        ph = (ph + 1) % 3;
      end else begin
        rready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pop expectations on each B/R handshake and check stall stability
  initial begin
    b_exp_t be;
    r_exp_t re, prev_r;
    logic [11:0] prev_bid;
    logic pr_stall, pb_stall;
    pr_stall = 1'b0; pb_stall = 1'b0; prev_r = '0; prev_bid = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pr_stall = 1'b0; pb_stall = 1'b0;
      end else begin
        if (pr_stall) begin
          chk("r_hold_valid", rvalid, 1'b1);
          chk("r_hold_fields", {rid, rdata, rresp, rlast}, prev_r);
        end
        if (pb_stall) begin
          chk("b_hold_valid", bvalid, 1'b1);
          chk("b_hold_id", bid, prev_bid);
        end
        if (bvalid) chk("aw_blocked", awready, 1'b0);
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected: bid=%h bresp=%0d expected no response", bid, bresp);
          end else begin
            be = bq.pop_front();
            chk("bid", bid, be.id);
            chk("bresp", bresp, be.resp);
          end
        end
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL r_unexpected: rdata=%h expected no beat", rdata);
          end else begin
            re = rq.pop_front();
            chk("rid", rid, re.id);
            chk("rdata", rdata, re.data);
            chk("rresp", rresp, re.resp);
            chk("rlast", rlast, re.last);
          end
        end
        pr_stall = rvalid && !rready;
        prev_r   = {rid, rdata, rresp, rlast};
        pb_stall = bvalid && !bready;
        prev_bid = bid;
      end
    end
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arburst = 2'b01; arvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // single write, LED, read back
    beat(0, 32'hA5A5A5A5, 4'hF, 1'b1);
    do_write(12'h123, 32'h0, 4'd0, 2'b01, 2'b00, 1'b1);
    chk("led_a5", led, 8'hA5);
    push_r(12'h045, 32'hA5A5A5A5, 2'b00, 1'b1);
    do_read(12'h045, 32'h0, 4'd0, 2'b01);

    // INCR write wrapping the index, read back with RREADY stalls
    beat(0, 32'd1, 4'hF, 1'b0); beat(1, 32'd2, 4'hF, 1'b0);
    beat(2, 32'd3, 4'hF, 1'b0); beat(3, 32'd4, 4'hF, 1'b1);
    do_write(12'h007, 32'h18, 4'd3, 2'b01, 2'b00, 1'b1);
    chk("led_03", led, 8'h03);
    rr_toggle = 1'b1;
    push_r(12'h009, 32'd1, 2'b00, 1'b0); push_r(12'h009, 32'd2, 2'b00, 1'b0);
    push_r(12'h009, 32'd3, 2'b00, 1'b0); push_r(12'h009, 32'd4, 2'b00, 1'b1);
    do_read(12'h009, 32'h18, 4'd3, 2'b01);
    rr_toggle = 1'b0;
    push_r(12'h00A, 32'd4, 2'b00, 1'b1);
    do_read(12'h00A, 32'h4, 4'd0, 2'b01);

    // byte strobes
    beat(0, 32'hFFFFFFFF, 4'hF, 1'b1);
    do_write(12'h011, 32'h8, 4'd0, 2'b01, 2'b00, 1'b1);
    beat(0, 32'h00001200, 4'h2, 1'b1);
    do_write(12'h012, 32'h8, 4'd0, 2'b01, 2'b00, 1'b1);
    push_r(12'h013, 32'hFFFF12FF, 2'b00, 1'b1);
    do_read(12'h013, 32'h8, 4'd0, 2'b01);

    // FIXED burst write and read, plus address aliasing
    beat(0, 32'h11, 4'hF, 1'b0); beat(1, 32'h22, 4'hF, 1'b1);
    do_write(12'h021, 32'hC, 4'd1, 2'b00, 2'b00, 1'b1);
    push_r(12'h022, 32'h22, 2'b00, 1'b0); push_r(12'h022, 32'h22, 2'b00, 1'b0);
    push_r(12'h022, 32'h22, 2'b00, 1'b1);
    do_read(12'h022, 32'hC, 4'd2, 2'b00);
    push_r(12'h023, 32'h22, 2'b00, 1'b1);
    do_read(12'h023, 32'h2E, 4'd0, 2'b01);

    // B channel backpressure
    bready = 1'b0;
    beat(0, 32'hBEEF0004, 4'hF, 1'b1);
    do_write(12'h0B4, 32'h10, 4'd0, 2'b01, 2'b00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("bvalid_stalled", bvalid, 1'b1);
    bready = 1'b1;
    drain();
    push_r(12'h0B5, 32'hBEEF0004, 2'b00, 1'b1);
    do_read(12'h0B5, 32'h10, 4'd0, 2'b01);

    // WRAP bursts are rejected
    beat(0, 32'hDEADBEEF, 4'hF, 1'b1);
    do_write(12'h031, 32'h0, 4'd0, 2'b10, 2'b10, 1'b1);
    chk("led_after_wrap", led, 8'h03);
    push_r(12'h032, 32'd3, 2'b00, 1'b1);
    do_read(12'h032, 32'h0, 4'd0, 2'b01);
    push_r(12'h033, 32'd0, 2'b10, 1'b0); push_r(12'h033, 32'd0, 2'b10, 1'b1);
    do_read(12'h033, 32'h4, 4'd1, 2'b10);

    // WLAST disagreeing with the beat count
    beat(0, 32'h5, 4'hF, 1'b1); beat(1, 32'h6, 4'hF, 1'b1);
    do_write(12'h041, 32'h14, 4'd1, 2'b01, 2'b10, 1'b1);
    beat(0, 32'h5, 4'hF, 1'b0); beat(1, 32'h6, 4'hF, 1'b0);
    do_write(12'h042, 32'h14, 4'd1, 2'b01, 2'b10, 1'b1);

    // reset during beat 2 of a 4-beat write
    awid = 12'h077; awaddr = 32'h10; awlen = 4'd3; awburst = 2'b01; awvalid = 1'b1;
    hs_wait(0, "aw_rst");
    awvalid = 1'b0;
    wdata = 32'h77777777; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    hs_wait(1, "w_rst");
    wdata = 32'h88888888;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("mid");
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_b_after_rst", bvalid, 1'b0);
    chk("awready_after_rst", awready, 1'b1);
    beat(0, 32'hCAFEF00D, 4'hF, 1'b1);
    do_write(12'h055, 32'h4, 4'd0, 2'b01, 2'b00, 1'b1);
    push_r(12'h056, 32'hCAFEF00D, 2'b00, 1'b1);
    do_read(12'h056, 32'h4, 4'd0, 2'b01);
    push_r(12'h057, 32'h0, 2'b00, 1'b1);
    do_read(12'h057, 32'h10, 4'd0, 2'b01);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
